// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle execute unit, single-cycle ALU ops plus bit-serial shifts
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctrl,
  input  logic [WIDTH-1:0] ALUop1,
  input  logic [WIDTH-1:0] ALUop2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUout,
  output logic             zero,
  output logic             illegal
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, work_q, work_d, alu_r, step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, shamt;
  logic [1:0] sop_q, sop_d;
  logic zero_q, zero_d, ill_q, ill_d, is_shift;
  assign shamt    = ALUop2[SHAMT_W-1:0];
  assign is_shift = ALUctrl inside {4'd5, 4'd6, 4'd7};
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = state_q == DONE;
  assign ALUout    = res_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;
  always_comb begin
    alu_r = '0;
    case (ALUctrl)
      4'd0: alu_r = ALUop1 + ALUop2;
      4'd1: alu_r = ALUop1 - ALUop2;
      4'd2: alu_r = ALUop1 & ALUop2;
      4'd3: alu_r = ALUop1 | ALUop2;
      4'd4: alu_r = ALUop1 ^ ALUop2;
      4'd5, 4'd6, 4'd7: alu_r = ALUop1;
      4'd8: alu_r = {{(WIDTH-1){1'b0}}, $signed(ALUop1) < $signed(ALUop2)};
      4'd9: alu_r = {{(WIDTH-1){1'b0}}, ALUop1 < ALUop2};
      default: alu_r = '0;
    endcase
  end
  // sop encodes the low two ALUctrl bits of the shift: 01 sll, 10 srl, 11 sra
  assign step = sop_q == 2'b01 ? work_q << 1 :
                sop_q == 2'b10 ? work_q >> 1 : {work_q[WIDTH-1], work_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sop_d = ALUctrl[1:0];
        ill_d = ALUctrl > 4'd9;
        if (is_shift && shamt != '0) begin
          work_d  = ALUop1;
          cnt_d   = shamt;
          state_d = SHIFT;
        end else begin
          res_d   = alu_r;
          zero_d  = alu_r == '0;
          state_d = DONE;
        end
      end
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          res_d   = step;
          zero_d  = step == '0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      work_q  <= '0;
      cnt_q   <= '0;
      sop_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
    end
  end
endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Multi-cycle execute unit that consumes the 4-bit ALUctrl code produced by the ALU control decoder, together with two operands, and returns a registered result and zero flag.
- Non-shift ops complete in one cycle.
- Shifts run iteratively, one bit per cycle, to keep the barrel shifter off the critical path.
- Sits between the decode/operand-select stage and writeback/branch-resolve, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2)
SHAMT_W, 5, shift-amount width, must equal log2(WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
ALUctrl  input  4  operation code (encoding below)
ALUop1  input  WIDTH  operand A
ALUop2  input  WIDTH  operand B (shift amount = ALUop2[SHAMT_W-1:0])
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
ALUout  output  WIDTH  result
zero  output  1  ALUout == 0
illegal  output  1  ALUctrl code was unassigned

Behaviour:
- ALUctrl encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 sll, 0110 srl, 0111 sra
  - 1000 slt (signed), 1001 sltu (unsigned)
  - 1010-1111 illegal
- Reset (async, any state): state=IDLE, ALUout=0, zero=0, illegal=0, out_valid=0, shift counter=0. in_ready=0 while rst is high.
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE (rst low). out_valid=1 only in DONE.
- Accept: in_valid && in_ready at edge N. Operands and ALUctrl are captured at this edge; input changes after N have no effect.
- Non-shift op, illegal op, or shift with shamt=0: result, zero and illegal are registered at edge N; state goes to DONE; out_valid is high from edge N.
- Shift with shamt=k>0:
  - Edge N: capture ALUop1 into a working register, counter=k, state goes to SHIFT.
  - Each SHIFT edge: shift the working register by exactly one bit and decrement the counter.
  - The edge that reaches counter=0 writes ALUout and zero and moves to DONE.
  - out_valid is high from edge N+k. Total latency = k cycles beyond the single-cycle case.
- Shift semantics:
  - sll fills with 0; srl fills with 0; sra replicates bit WIDTH-1 of the working register.
  - Upper bits ALUop2[WIDTH-1:SHAMT_W] are ignored.
- Arithmetic: add/sub wrap modulo 2^WIDTH; no overflow or carry flag.
- slt/sltu: ALUout = 1 if A<B else 0, zero-extended to WIDTH. slt compares two's complement; sltu compares unsigned.
- Illegal code: ALUout=0, zero=1, illegal=1, same latency as a non-shift op. Legal ops register illegal=0.
- zero is computed from the final registered result only, never from intermediate shift values.
- DONE: ALUout, zero and illegal are held stable while out_valid && !out_ready. On out_ready, go to IDLE at that edge; out_valid drops.
- No overlap: a new request cannot be accepted in the same cycle as the output handshake. Minimum spacing between accepts is 2 cycles (non-shift) or k+2 cycles (shift).
- in_valid while busy: ignored, no capture; the requester must hold the request until in_ready.
- out_ready while not out_valid: ignored.
- rst asserted mid-SHIFT or in DONE: operation is aborted and no out_valid pulse is emitted. After rst deasserts, the unit is in IDLE with in_ready=1 on the next cycle.
- No combinational path from in_valid/ALUop*/ALUctrl to any output. in_ready depends only on state and rst.

Test Plan:
- add 0xFFFFFFFF + 0x00000001 -> out_valid one cycle after accept, ALUout=0x00000000, zero=1, illegal=0. Then sub 5-7 -> ALUout=0xFFFFFFFE, zero=0.
- sra 0x80000000 by ALUop2=0x00000024 (shamt 4, upper bits ignored) -> out_valid exactly 4 cycles after the single-cycle case, ALUout=0xF8000000, in_ready=0 throughout. Also srl of the same operands -> 0x08000000.
- slt 0xFFFFFFFF vs 0x00000001 -> ALUout=1; sltu with the same operands -> ALUout=0, zero=1.
- Backpressure: complete xor 0xA5A5A5A5^0xFFFFFFFF with out_ready=0 for 5 cycles -> ALUout=0x5A5A5A5A held, in_valid ignored. Then out_ready=1 -> IDLE; next request accepted no earlier than the following cycle.
- ALUctrl=1011 -> ALUout=0, zero=1, illegal=1. sll by shamt 0 of 0x12345678 -> single-cycle result 0x12345678, illegal=0.
- Assert rst two cycles into an sll by 31 -> outputs return to reset values immediately, no out_valid. After release, add 2+3 -> ALUout=5.
